// File: rtl/pipelined_barrel_shifter_if.sv
// Operand/result handshake bundle for the pipelined barrel shifter.
// The slave modport is the shifter's view; master is the producer/consumer view.
interface pipelined_barrel_shifter_if #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [SHW-1:0]   in_b;
  logic [2:0]       in_op;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_carry;

  modport master (
    output in_valid, in_a, in_b, in_op, out_ready,
    input  in_ready, out_valid, out_data, out_carry
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, out_ready,
    output in_ready, out_valid, out_data, out_carry
  );

endinterface

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter: SRA/SRL/SLL/ROR/ROL/pass on WIDTH-bit operands with a
// carry-out of the last bit shifted out. The SHW mux levels (level k shifts by 2^k)
// are spread over STAGES register slices, earlier slices taking any extra level.
// Each slice carries valid, op, the shift amount and the pending carry with its data.
module pipelined_barrel_shifter #(
  parameter int WIDTH  = 32,
  parameter int SHW    = $clog2(WIDTH),
  parameter int STAGES = 2
) (
  input  logic                        clk,
  input  logic                        resetn,
  pipelined_barrel_shifter_if.slave   bus
);

  typedef enum logic [2:0] {
    OP_SRA   = 3'b000,
    OP_SRL   = 3'b001,
    OP_SLL   = 3'b010,
    OP_SLL_A = 3'b011,
    OP_ROR   = 3'b100,
    OP_ROL   = 3'b101,
    OP_PASS  = 3'b110,
    OP_PASS_A= 3'b111
  } op_e;

  // First mux level owned by slice s.
  function automatic int unsigned lvl_lo(input int unsigned s);
    int unsigned base;
    int unsigned extra;
    base  = SHW / STAGES;
    extra = SHW % STAGES;
    return s * base + ((s < extra) ? s : extra);
  endfunction

  // Number of mux levels owned by slice s.
  function automatic int unsigned lvl_cnt(input int unsigned s);
    int unsigned base;
    int unsigned extra;
    base  = SHW / STAGES;
    extra = SHW % STAGES;
    return base + ((s < extra) ? 1 : 0);
  endfunction

  // Slice registers
  logic [STAGES-1:0] r_valid;
  logic [STAGES-1:0] r_carry;
  logic [WIDTH-1:0]  r_data [STAGES];
  logic [2:0]        r_op   [STAGES];
  logic [SHW-1:0]    r_b    [STAGES];

  // Slice inputs (upstream view) and slice next-state values
  logic [STAGES-1:0] w_src_valid;
  logic [STAGES-1:0] w_src_carry;
  logic [WIDTH-1:0]  w_src_data [STAGES];
  logic [2:0]        w_src_op   [STAGES];
  logic [SHW-1:0]    w_src_b    [STAGES];

  logic [STAGES-1:0] w_carry;
  logic [WIDTH-1:0]  w_data [STAGES];

  logic [STAGES:0]   w_ready;

  // Per-slice working variables of the shift network
  logic [WIDTH-1:0]  w_cur;
  logic              w_c;
  logic              w_pass;
  int unsigned       w_s;
  logic [SHW-1:0]    w_ir;
  logic [SHW-1:0]    w_il;

  // Route each slice's upstream: the input port for slice 0, the previous slice otherwise.
  always_comb begin
    w_src_valid   = '0;
    w_src_carry   = '0;
    for (int unsigned i = 0; i < STAGES; i++) begin
      w_src_data[i] = '0;
      w_src_op[i]   = '0;
      w_src_b[i]    = '0;
    end
    w_src_valid[0] = bus.in_valid;
    w_src_carry[0] = 1'b0;
    w_src_data[0]  = bus.in_a;
    w_src_op[0]    = bus.in_op;
    w_src_b[0]     = bus.in_b;
    for (int unsigned i = 1; i < STAGES; i++) begin
      w_src_valid[i] = r_valid[i-1];
      w_src_carry[i] = r_carry[i-1];
      w_src_data[i]  = r_data[i-1];
      w_src_op[i]    = r_op[i-1];
      w_src_b[i]     = r_b[i-1];
    end
  end

  // Ready chain, evaluated from the output back so a full pipe can move every cycle.
  always_comb begin
    w_ready         = '0;
    w_ready[STAGES] = bus.out_ready;
    for (int unsigned i = STAGES; i > 0; i--) begin
      w_ready[i-1] = !r_valid[i-1] | w_ready[i];
    end
  end

  // Shift network: each slice applies the mux levels it owns to its upstream beat.
  // Every applied level overwrites the carry, so the carry left behind belongs to the
  // highest set bit of b: for shifts that is the last bit lost, for rotates it equals
  // the bit that landed at the far end (MSB for ROR, LSB for ROL).
  always_comb begin
    w_carry = '0;
    w_cur   = '0;
    w_c     = 1'b0;
    w_pass  = 1'b0;
    w_s     = 0;
    w_ir    = '0;
    w_il    = '0;
    for (int unsigned i = 0; i < STAGES; i++) begin
      w_data[i] = '0;
    end
    for (int unsigned i = 0; i < STAGES; i++) begin
      w_cur  = w_src_data[i];
      w_c    = w_src_carry[i];
      w_pass = (w_src_op[i][2:1] == 2'b11);
      for (int unsigned k = 0; k < SHW; k++) begin
        if ((k >= lvl_lo(i)) && (k < lvl_lo(i) + lvl_cnt(i)) && w_src_b[i][k] && !w_pass) begin
          w_s  = 1 << k;
          w_ir = SHW'(w_s - 1);
          w_il = SHW'(WIDTH - w_s);
          case (op_e'(w_src_op[i]))
            OP_SRA: begin
              w_c   = w_cur[w_ir];
              w_cur = $signed(w_cur) >>> w_s;
            end
            OP_SRL: begin
              w_c   = w_cur[w_ir];
              w_cur = w_cur >> w_s;
            end
            OP_SLL, OP_SLL_A: begin
              w_c   = w_cur[w_il];
              w_cur = w_cur << w_s;
            end
            OP_ROR: begin
              w_c   = w_cur[w_ir];
              w_cur = (w_cur >> w_s) | (w_cur << (WIDTH - w_s));
            end
            OP_ROL: begin
              w_c   = w_cur[w_il];
              w_cur = (w_cur << w_s) | (w_cur >> (WIDTH - w_s));
            end
            default: ;
          endcase
        end
      end
      w_data[i]  = w_cur;
      w_carry[i] = w_c;
    end
  end

  // Slice registers: a slice loads whenever it is ready; payload only follows a valid beat
  // so the outputs never pick up undriven operand values.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_valid <= '0;
      r_carry <= '0;
      for (int unsigned i = 0; i < STAGES; i++) begin
        r_data[i] <= '0;
        r_op[i]   <= '0;
        r_b[i]    <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        if (w_ready[i]) begin
          r_valid[i] <= w_src_valid[i];
          if (w_src_valid[i]) begin
            r_carry[i] <= w_carry[i];
            r_data[i]  <= w_data[i];
            r_op[i]    <= w_src_op[i];
            r_b[i]     <= w_src_b[i];
          end
        end
      end
    end
  end

  assign bus.in_ready  = w_ready[0];
  assign bus.out_valid = r_valid[STAGES-1];
  assign bus.out_data  = r_data[STAGES-1];
  assign bus.out_carry = r_carry[STAGES-1];

endmodule
